// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl
//   Instruction-fetch sequencer for the 16-bit RISC core. It owns the fetch
//   PC (fpc) that addresses a combinational instruction memory. Each returned
//   instruction is captured with its PC into a small prefetch FIFO, and the
//   FIFO head is presented to decode. It also handles branch redirects
//   (flush plus refetch), end-of-ROM detection and misaligned-target faults.
//
// Ports
//   clk        in   clock; all state updates on the rising edge
//   rst_n      in   asynchronous active-low reset
//   imem_pc    out  fetch PC register, drives the instruction memory address
//   imem_instr in   combinational read data for imem_pc
//   br_valid   in   redirect request, one-cycle pulse
//   br_target  in   redirect byte address
//   out_valid  out  FIFO head holds an instruction
//   out_ready  in   decode accepts the head this cycle
//   out_instr  out  head instruction, 0 when empty
//   out_pc     out  PC of head instruction, 0 when empty
//   done       out  fetch PC has passed the last ROM word (END state)
//   fault      out  sticky; a misaligned redirect target was received
//   dbg_state  out  current FSM state (RUN=0, END=1, FAULT=2)
//
// Handshake: a head entry transfers to decode on every rising edge where
// out_valid and out_ready are both high. out_valid never depends
// combinationally on out_ready, and the head stays stable until it is taken.

module instr_fetch_ctrl #(
    parameter int                 PC_SIZE              = 16,
    parameter int                 INSTRUCTION_SIZE     = 16,
    parameter int                 INSTRUCTION_ROM_SIZE = 32,
    parameter int                 FIFO_DEPTH           = 2,
    parameter logic [PC_SIZE-1:0] RESET_PC             = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic [PC_SIZE-1:0]          imem_pc,
    input  logic [INSTRUCTION_SIZE-1:0] imem_instr,
    input  logic                        br_valid,
    input  logic [PC_SIZE-1:0]          br_target,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [INSTRUCTION_SIZE-1:0] out_instr,
    output logic [PC_SIZE-1:0]          out_pc,
    output logic                        done,
    output logic                        fault,
    output logic [1:0]                  dbg_state
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    // First byte address beyond the last ROM word.
    localparam logic [PC_SIZE-1:0] PC_LIMIT = PC_SIZE'(2 * INSTRUCTION_ROM_SIZE);
    localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [PC_SIZE-1:0] PC_STEP  = PC_SIZE'(2);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_END   = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    state_e                      state_q, state_d;
    logic [PC_SIZE-1:0]          fpc_q, fpc_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]            count_q, count_d;

    logic [PC_SIZE-1:0]          pc_mem_q    [FIFO_DEPTH];
    logic [INSTRUCTION_SIZE-1:0] instr_mem_q [FIFO_DEPTH];

    logic                        pop;
    logic                        push;
    logic [PC_SIZE-1:0]          fpc_inc;

    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    assign fpc_inc   = fpc_q + PC_STEP;

    // ------------------------------------------------------------------
    // Next-state and FIFO control
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        fpc_d    = fpc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        push     = 1'b0;

        unique case (state_q)
            ST_RUN, ST_END: begin
                if (br_valid) begin
                    // Any redirect empties the FIFO. For an aligned target the
                    // head popped this cycle has already been consumed by decode;
                    // everything behind it is wrong-path and is dropped.
                    rd_ptr_d = '0;
                    wr_ptr_d = '0;
                    count_d  = '0;
                    if (br_target[0]) begin
                        state_d = ST_FAULT;
                    end else begin
                        fpc_d   = br_target;
                        state_d = ST_RUN;
                    end
                end else begin
                    if (pop) begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                    if (state_q == ST_RUN) begin
                        if (fpc_q >= PC_LIMIT) begin
                            // Reached only after a redirect to an out-of-range target.
                            state_d = ST_END;
                        end else if ((count_q != CNT_FULL) || pop) begin
                            push     = 1'b1;
                            wr_ptr_d = wr_ptr_q + 1'b1;
                            fpc_d    = fpc_inc;
                            if (fpc_inc >= PC_LIMIT) begin
                                state_d = ST_END;
                            end
                        end
                    end
                    if (push && !pop) begin
                        count_d = count_q + 1'b1;
                    end else if (!push && pop) begin
                        count_d = count_q - 1'b1;
                    end
                end
            end
            ST_FAULT: begin
                // Terminal until reset; FIFO is already empty.
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            fpc_q    <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            fpc_q    <= fpc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= fpc_q;
            instr_mem_q[wr_ptr_q] <= imem_instr;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_pc   = fpc_q;
    assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : '0;
    assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q] : '0;
    assign done      = (state_q == ST_END);
    assign fault     = (state_q == ST_FAULT);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed testbench for instr_fetch_ctrl: sequential run, backpressure,
// aligned redirect, misaligned redirect, redirect out of END and redirect
// to an out-of-range target. The ROM model returns 16'hA000 + word index.

module tb_instr_fetch_ctrl;

    localparam int PW = 16;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [PW-1:0] imem_pc;
    logic [IW-1:0] imem_instr;
    logic          br_valid = 1'b0;
    logic [PW-1:0] br_target = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [IW-1:0] out_instr;
    logic [PW-1:0] out_pc;
    logic          done;
    logic          fault;
    logic [1:0]    dbg_state;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ROM model: 32 words, word i = A000+i; out-of-range reads return DEAD.
    assign imem_instr = (imem_pc < 16'd64) ? (16'hA000 + {1'b0, imem_pc[15:1]}) : 16'hDEAD;

    instr_fetch_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_pc    (imem_pc),
        .imem_instr (imem_instr),
        .br_valid   (br_valid),
        .br_target  (br_target),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .done       (done),
        .fault      (fault),
        .dbg_state  (dbg_state)
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one cycle; return at the falling edge so outputs are stable.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Assert reset between edges, check the asynchronous reset values, and
    // release at a falling edge so the next rising edge is the first fetch.
    task automatic do_reset(input string tag);
        @(negedge clk);
        br_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_rst_pc"},    32'(imem_pc),   32'h0);
        check({tag, "_rst_valid"}, 32'(out_valid), 32'h0);
        check({tag, "_rst_instr"}, 32'(out_instr), 32'h0);
        check({tag, "_rst_opc"},   32'(out_pc),    32'h0);
        check({tag, "_rst_done"},  32'(done),      32'h0);
        check({tag, "_rst_fault"}, 32'(fault),     32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic redirect(input logic [PW-1:0] tgt);
        br_valid  = 1'b1;
        br_target = tgt;
        step();
        br_valid  = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // ---- sequential run ----
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back({16'(2 * i), 16'hA000 + 16'(i)});
        end
        out_ready = 1'b1;
        do_reset("seq");
        check("seq_pre_valid", 32'(out_valid), 32'h0);
        for (int c = 1; c <= 32; c++) begin
            logic [31:0] e;
            step();
            e = exp_q.pop_front();
            check("seq_valid", 32'(out_valid), 32'h1);
            check("seq_head", {out_pc, out_instr}, e);
            check("seq_done", 32'(done), (c >= 32) ? 32'h1 : 32'h0);
        end
        step();
        check("seq_end_valid", 32'(out_valid), 32'h0);
        check("seq_end_done",  32'(done),      32'h1);
        check("seq_end_opc",   32'(out_pc),    32'h0);
        check("seq_end_instr", 32'(out_instr), 32'h0);

        // ---- backpressure ----
        out_ready = 1'b0;
        do_reset("bp");
        step();
        check("bp_first_valid", 32'(out_valid), 32'h1);
        check("bp_first_opc",   32'(out_pc),    32'h0);
        check("bp_first_ipc",   32'(imem_pc),   32'h2);
        for (int c = 0; c < 5; c++) begin
            step();
            check("bp_hold_ipc", 32'(imem_pc), 32'h4);
            check("bp_hold_opc", 32'(out_pc),  32'h0);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("bp_rel_valid", 32'(out_valid), 32'h1);
            check("bp_rel_opc", 32'(out_pc), 32'(2 * k));
            check("bp_rel_instr", 32'(out_instr), 32'h0000A000 + 32'(k));
            step();
        end

        // ---- aligned redirect with pc 6 and 8 queued ----
        out_ready = 1'b1;
        do_reset("br");
        for (int c = 0; c < 4; c++) step();
        check("br_head6", 32'(out_pc), 32'h6);
        out_ready = 1'b0;
        step();
        check("br_q_head", 32'(out_pc),  32'h6);
        check("br_q_ipc",  32'(imem_pc), 32'hA);
        out_ready = 1'b1;
        redirect(16'h0010);
        check("br_bubble_valid", 32'(out_valid), 32'h0);
        check("br_bubble_ipc",   32'(imem_pc),   32'h10);
        step();
        check("br_tgt_valid", 32'(out_valid), 32'h1);
        check("br_tgt_opc",   32'(out_pc),    32'h10);
        check("br_tgt_instr", 32'(out_instr), 32'hA008);
        check("br_tgt_ipc",   32'(imem_pc),   32'h12);
        step();
        check("br_next_opc",   32'(out_pc),    32'h12);
        check("br_next_instr", 32'(out_instr), 32'hA009);
        check("br_next_ipc",   32'(imem_pc),   32'h14);

        // ---- misaligned redirect ----
        redirect(16'h0013);
        check("mis_fault", 32'(fault),     32'h1);
        check("mis_valid", 32'(out_valid), 32'h0);
        check("mis_ipc",   32'(imem_pc),   32'h14);
        check("mis_done",  32'(done),      32'h0);
        step();
        step();
        check("mis_hold_ipc", 32'(imem_pc), 32'h14);
        redirect(16'h0000);
        check("mis_ign_fault", 32'(fault),     32'h1);
        check("mis_ign_valid", 32'(out_valid), 32'h0);
        check("mis_ign_ipc",   32'(imem_pc),   32'h14);
        do_reset("mis");
        check("mis_post_fault", 32'(fault), 32'h0);

        // ---- redirect out of END ----
        out_ready = 1'b1;
        for (int c = 0; c < 33; c++) step();
        check("end_done",  32'(done),      32'h1);
        check("end_valid", 32'(out_valid), 32'h0);
        check("end_ipc",   32'(imem_pc),   32'h40);
        redirect(16'h0000);
        check("end_br_done",  32'(done),      32'h0);
        check("end_br_valid", 32'(out_valid), 32'h0);
        check("end_br_ipc",   32'(imem_pc),   32'h0);
        step();
        check("end_re_valid", 32'(out_valid), 32'h1);
        check("end_re_opc",   32'(out_pc),    32'h0);
        check("end_re_instr", 32'(out_instr), 32'hA000);

        // ---- redirect out of range ----
        redirect(16'h0040);
        check("oor_done0",  32'(done),      32'h0);
        check("oor_valid0", 32'(out_valid), 32'h0);
        check("oor_ipc0",   32'(imem_pc),   32'h40);
        for (int c = 0; c < 3; c++) begin
            step();
            check("oor_done",  32'(done),      32'h1);
            check("oor_valid", 32'(out_valid), 32'h0);
            check("oor_ipc",   32'(imem_pc),   32'h40);
        end

        // ---- final report ----
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
